// File: rtl/secuenciador_coeficientes.sv
// Band-switch sequencer for the IIR coefficient mux bank: waits for a sample boundary,
// then flushes the delay line, strobes the coefficient registers and mutes the output.
module secuenciador_coeficientes #(
    parameter int FLUSH_CYCLES = 4,
    parameter int MUTE_SAMPLES = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       req_valid,
    input  logic [1:0] req_sel,
    output logic       req_ready,
    input  logic       sample_tick,
    output logic [1:0] sel,
    output logic       coef_load,
    output logic       flush,
    output logic       mute,
    output logic       busy
);
    localparam int FW = $clog2((FLUSH_CYCLES > 1) ? FLUSH_CYCLES : 1) + 1;
    localparam int MW = $clog2((MUTE_SAMPLES > 1) ? MUTE_SAMPLES : 1) + 1;
    localparam logic [FW-1:0] FLUSH_LAST = FW'(FLUSH_CYCLES - 1);
    localparam logic [MW-1:0] MUTE_LAST  = MW'((MUTE_SAMPLES > 0) ? MUTE_SAMPLES - 1 : 0);

    typedef enum logic [2:0] {
        S_IDLE,
        S_WAIT_TICK,
        S_FLUSH,
        S_LOAD,
        S_MUTE
    } state_t;

    state_t          state_q;
    logic [1:0]      sel_q;
    logic [1:0]      pend_sel_q;
    logic            coef_load_q;
    logic            flush_q;
    logic            mute_q;
    logic            busy_q;
    logic [FW-1:0]   flush_cnt_q;
    logic [MW-1:0]   mute_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= 2'b00;
            pend_sel_q  <= 2'b00;
            coef_load_q <= 1'b0;
            flush_q     <= 1'b0;
            mute_q      <= 1'b0;
            busy_q      <= 1'b0;
            flush_cnt_q <= '0;
            mute_cnt_q  <= '0;
        end else begin
            coef_load_q <= 1'b0;
            unique case (state_q)
                S_IDLE: begin
                    // req_ready is high here, so req_valid alone marks a transfer
                    if (req_valid) begin
                        pend_sel_q <= req_sel;
                        if (req_sel != sel_q) begin
                            state_q <= S_WAIT_TICK;
                            mute_q  <= 1'b1;
                            busy_q  <= 1'b1;
                        end
                    end
                end
                S_WAIT_TICK: begin
                    if (sample_tick) begin
                        state_q     <= S_FLUSH;
                        sel_q       <= pend_sel_q;
                        flush_q     <= 1'b1;
                        flush_cnt_q <= '0;
                    end
                end
                S_FLUSH: begin
                    if (flush_cnt_q == FLUSH_LAST) begin
                        state_q     <= S_LOAD;
                        flush_q     <= 1'b0;
                        coef_load_q <= 1'b1;
                    end else begin
                        flush_cnt_q <= flush_cnt_q + FW'(1);
                    end
                end
                S_LOAD: begin
                    // a tick coincident with the load strobe is deliberately not counted
                    mute_cnt_q <= '0;
                    if (MUTE_SAMPLES > 0) begin
                        state_q <= S_MUTE;
                    end else begin
                        state_q <= S_IDLE;
                        mute_q  <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                end
                S_MUTE: begin
                    if (sample_tick) begin
                        if (mute_cnt_q == MUTE_LAST) begin
                            state_q <= S_IDLE;
                            mute_q  <= 1'b0;
                            busy_q  <= 1'b0;
                        end else begin
                            mute_cnt_q <= mute_cnt_q + MW'(1);
                        end
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign req_ready = (state_q == S_IDLE) & ~reset;
    assign sel       = sel_q;
    assign coef_load = coef_load_q;
    assign flush     = flush_q;
    assign mute      = mute_q;
    assign busy      = busy_q;

endmodule
